sp_cfg_ctrl: RTL and testbench
==============================

Name: sp_cfg_ctrl

Overview:
Configuration sequencer for the SuperMario chip's reset and SPI pins. On start it holds the chip in reset and releases it. It then writes a table of register entries over SPI and can read each entry back to verify it. When finished it asserts ready, so the readout path (sp_rd) can take over the data pins with the chip configured.

Parameters:
DEPTH, 16, number of entries in the configuration table
AW, 4, table address width (clog2(DEPTH))
RST_CYCLES, 16, cycles sp_nrst is held low after start
WAKE_CYCLES, 8, cycles from sp_nrst release to the first SPI frame
GAP_CYCLES, 2, idle cycles (cs high) between frames
MISO_LAT, 1, chip delay from a read-data bit slot to its valid MISO bit

Ports:
clk  in  1  system clock; SP_CLK is clk forwarded, so SPI bits are clk-synchronous
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse: begin a reset-and-configure sequence
verify_en  in  1  sampled at start; 1 = read back every entry after the writes
n_entries  in  AW+1  sampled at start; number of valid table entries
tbl_we  in  1  table write strobe
tbl_addr  in  AW  table write index
tbl_data  in  15  {reg_addr[6:0], reg_data[7:0]}
busy  out  1  sequence in progress
done  out  1  single-cycle pulse at sequence end
ready  out  1  level: chip configured (and verified if enabled)
err  out  1  level: at least one readback mismatch in the last sequence
err_cnt  out  AW+1  mismatch count, saturating
err_idx  out  AW  table index of the first mismatch
sp_nrst  out  1  chip reset, active-low
sp_spi_cs  out  1  SPI chip select, active-low, idle high
sp_spi_mosi  out  1  SPI data to chip
sp_spi_miso  in  1  SPI data from chip

Behaviour:
- Reset (asynchronous, any state): sp_nrst=0, sp_spi_cs=1, sp_spi_mosi=0, busy=0, done=0, ready=0, err=0, err_cnt=0, err_idx=0. FSM goes to IDLE. Table contents are not reset.
- Table: register array. Writes take effect at the clk edge when tbl_we=1. tbl_we is ignored while busy, so the table is frozen during a sequence.
- FSM states:
  - IDLE: on start, latch verify_en and n_entries (clamp to DEPTH), clear err, err_cnt, err_idx and ready; go to CHIP_RST. busy=1 from the cycle after start. start while busy is ignored.
  - CHIP_RST: sp_nrst=0 for RST_CYCLES cycles, then go to WAKE.
  - WAKE: sp_nrst=1 (it stays 1 until the next start or rst); wait WAKE_CYCLES. If n_entries=0, go to FIN; otherwise go to WR with idx=0.
  - WR / RD frames are 16 cycles with sp_spi_cs=0. mosi carries the command MSB first, one bit per cycle:
    - bit15: 1=write, 0=read
    - bits14:8: reg_addr
    - bits7:0: reg_data for writes, 0 for reads
  - HOLD: 1 cycle with sp_spi_cs=1, then GAP for GAP_CYCLES cycles with cs high and mosi=0. Next state after GAP:
    - next idx in the same phase, or
    - after the last write: RD (idx=0) if verify_en, else FIN
    - after the last read: FIN
- Read sampling: miso is registered in frame cycles 8+MISO_LAT through 15+MISO_LAT, MSB first. When MISO_LAT>0, the final samples are taken during HOLD/GAP; GAP_CYCLES must be >= MISO_LAT.
- Compare the assembled byte with the table's reg_data. On mismatch:
  - set err
  - increment err_cnt, saturating at all-ones
  - record idx in err_idx on the first mismatch only
- FIN: done=1 for one cycle and busy=0 in the same cycle. ready=1 if no error (ready stays 0 when err=1). Return to IDLE.
- A new start from IDLE drops ready immediately and re-resets the chip.
- Outputs are registered; mosi and cs change only on rising clk.

Test Plan:
- Write-only sequence, RST_CYCLES=16, WAKE_CYCLES=8, table {0x05:0xA3, 0x7F:0x01}, n_entries=2, verify_en=0, start at cycle 0:
  - sp_nrst low cycles 1-16
  - frame 0x85A3 on mosi in cycles 25-40, cs high at 41
  - frame 0xFF01 after 2 gap cycles
  - done pulse, ready=1, err=0
- Verify pass, same table, verify_en=1, chip model echoes the written bytes:
  - read frames 0x0500 and 0x7F00 follow the writes
  - err_cnt=0, ready=1
- Verify fail, chip model returns 0x00 for addr 0x7F:
  - err=1, err_cnt=1, err_idx=1, ready=0, done pulses
- n_entries=0: no cs activity; done one cycle after WAKE ends. n_entries=31 with DEPTH=16: exactly 16 write frames.
- rst asserted mid-frame (cycle 30): same cycle sp_spi_cs=1, sp_nrst=0, busy=0. A new start runs the full sequence from CHIP_RST.
- start pulsed while busy and tbl_we while busy: sequence timing unchanged and table contents unchanged (readback still matches the original values).

Source files
------------

// File: rtl/sp_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sp_cfg_ctrl
//  Description : Reset-and-configure sequencer for the SuperMario chip.
//                Pulses the chip reset, writes a table of register entries
//                over SPI, optionally reads each entry back to verify it,
//                and then raises ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_cfg_ctrl #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int RST_CYCLES  = 16,
  parameter int WAKE_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int MISO_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          verify_en,
  input  logic [AW:0]   n_entries,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [14:0]   tbl_data,
  output logic          busy,
  output logic          done,
  output logic          ready,
  output logic          err,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] err_idx,
  output logic          sp_nrst,
  output logic          sp_spi_cs,
  output logic          sp_spi_mosi,
  input  logic          sp_spi_miso
);

  // One counter runs through a whole frame slot: 0..15 is the cs-low frame,
  // 16 is HOLD and 17..16+GAP_CYCLES is the gap. It is reused for the reset
  // and wake timers.
  localparam int c_cnt_max_a = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
  localparam int c_cnt_max   = (c_cnt_max_a > 17 + GAP_CYCLES) ? c_cnt_max_a : 17 + GAP_CYCLES;
  localparam int c_cnt_w     = $clog2(c_cnt_max);

  localparam logic [c_cnt_w-1:0] c_rst_last   = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_wake_last  = c_cnt_w'(WAKE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(15);
  localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(16 + GAP_CYCLES);
  localparam logic [c_cnt_w-1:0] c_samp_first = c_cnt_w'(8 + MISO_LAT);
  localparam logic [c_cnt_w-1:0] c_samp_last  = c_cnt_w'(15 + MISO_LAT);
  localparam logic [AW:0]        c_depth      = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHIP_RST = 3'd1,
    S_WAKE     = 3'd2,
    S_WR       = 3'd3,
    S_RD       = 3'd4,
    S_HOLD     = 3'd5,
    S_GAP      = 3'd6,
    S_FIN      = 3'd7
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [AW-1:0]        r_idx, w_idx_nxt;
  logic                 r_rd_phase, w_rd_phase_nxt;
  logic                 r_verify;
  logic [AW:0]          r_n;
  logic [6:0]           r_shift;
  logic [14:0]          r_tbl [DEPTH];

  logic                 r_busy, r_done, r_ready, r_err;
  logic [AW:0]          r_err_cnt;
  logic [AW-1:0]        r_err_idx;
  logic                 r_nrst, r_cs, r_mosi;

  logic [AW:0]          w_n_clamp;
  logic                 w_last;
  logic                 w_start_ok;
  logic [14:0]          w_entry;
  logic [15:0]          w_cmd;
  logic                 w_mosi_nxt;
  logic                 w_in_rd;
  logic                 w_samp;
  logic                 w_mismatch;
  logic [7:0]           w_byte;

  assign w_n_clamp  = (n_entries > c_depth) ? c_depth : n_entries;
  assign w_last     = (({1'b0, r_idx} + 1'b1) == r_n);
  assign w_start_ok = (r_state == S_IDLE) && start;

  // Command for the frame about to be driven, built from next-cycle index/phase
  assign w_entry    = r_tbl[w_idx_nxt];
  assign w_cmd      = {~w_rd_phase_nxt, w_entry[14:8], (w_rd_phase_nxt ? 8'h00 : w_entry[7:0])};
  assign w_mosi_nxt = ((w_state_nxt == S_WR) || (w_state_nxt == S_RD)) ?
                      w_cmd[4'd15 - w_cnt_nxt[3:0]] : 1'b0;

  // Readback bits arrive MISO_LAT cycles after their slot, possibly in HOLD/GAP
  assign w_in_rd    = r_rd_phase && ((r_state == S_RD) || (r_state == S_HOLD) || (r_state == S_GAP));
  assign w_samp     = w_in_rd && (r_cnt >= c_samp_first) && (r_cnt <= c_samp_last);
  assign w_byte     = {r_shift, sp_spi_miso};
  assign w_mismatch = w_in_rd && (r_cnt == c_samp_last) && (w_byte != r_tbl[r_idx][7:0]);

  // Configuration table: frozen while a sequence is running
  always_ff @(posedge clk) begin
    if (tbl_we && !r_busy) r_tbl[tbl_addr] <= tbl_data;
  end

  // Sequencer state, slot counter, table index and phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rd_phase <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_rd_phase <= w_rd_phase_nxt;
    end
  end

  // Next-state logic; HOLD and GAP share the end-of-slot decision so a
  // zero-length gap still works
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_rd_phase_nxt = r_rd_phase;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CHIP_RST;
          w_cnt_nxt   = '0;
        end
      end
      S_CHIP_RST: begin
        if (r_cnt == c_rst_last) begin
          w_state_nxt = S_WAKE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_WAKE: begin
        if (r_cnt == c_wake_last) begin
          w_cnt_nxt      = '0;
          w_idx_nxt      = '0;
          w_rd_phase_nxt = 1'b0;
          w_state_nxt    = (r_n == '0) ? S_FIN : S_WR;
        end else begin
          w_cnt_nxt      = r_cnt + 1'b1;
        end
      end
      S_WR, S_RD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_frame_last) w_state_nxt = S_HOLD;
      end
      S_HOLD, S_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_cnt_nxt = '0;
          if (!w_last) begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = r_rd_phase ? S_RD : S_WR;
          end else if (!r_rd_phase && r_verify) begin
            w_idx_nxt      = '0;
            w_rd_phase_nxt = 1'b1;
            w_state_nxt    = S_RD;
          end else begin
            w_state_nxt    = S_FIN;
          end
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered pin and status outputs, derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_err_idx <= '0;
      r_nrst    <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
      r_verify  <= 1'b0;
      r_n       <= '0;
      r_shift   <= '0;
    end else begin
      r_busy <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_FIN));
      r_done <= (w_state_nxt == S_FIN);
      r_cs   <= !((w_state_nxt == S_WR) || (w_state_nxt == S_RD));
      r_mosi <= w_mosi_nxt;
      if (w_state_nxt == S_CHIP_RST)  r_nrst <= 1'b0;
      else if (w_state_nxt != S_IDLE) r_nrst <= 1'b1;

      if (w_start_ok) begin
        r_verify  <= verify_en;
        r_n       <= w_n_clamp;
        r_ready   <= 1'b0;
        r_err     <= 1'b0;
        r_err_cnt <= '0;
        r_err_idx <= '0;
      end else begin
        if (w_samp) r_shift <= w_byte[6:0];
        if (w_mismatch) begin
          r_err <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          if (!r_err)          r_err_idx <= r_idx;
        end
        if (w_state_nxt == S_FIN) r_ready <= !(r_err || w_mismatch);
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign ready       = r_ready;
  assign err         = r_err;
  assign err_cnt     = r_err_cnt;
  assign err_idx     = r_err_idx;
  assign sp_nrst     = r_nrst;
  assign sp_spi_cs   = r_cs;
  assign sp_spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_sp_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_cfg_ctrl
//  Description : Scoreboard bench for sp_cfg_ctrl with a behavioural SPI chip.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_cfg_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RSTC  = 16;
  localparam int WAKEC = 8;
  localparam int GAPC  = 2;
  localparam int LAT   = 1;
  localparam int FIRST = 1 + RSTC + WAKEC;   // cycle of first frame / done when empty
  localparam int SLOT  = 16 + 1 + GAPC;      // frame + hold + gap

  typedef struct { logic [15:0] val; int rel; } frame_t;
  typedef struct { int rel; int err; int cnt; int idx; int rdy; } status_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          verify_en = 1'b0;
  logic [AW:0]   n_entries = '0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [14:0]   tbl_data = '0;
  logic          busy, done, ready, err, sp_nrst, sp_spi_cs, sp_spi_mosi;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] err_idx;
  logic          sp_spi_miso = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s_start = 0;
  bit seq_active = 1'b0;
  bit abort = 1'b0;
  int done_count = 0;
  int dc_before = 0;

  frame_t  exp_frames[$];
  status_t exp_status[$];

  logic [14:0] tb_tbl [DEPTH];
  bit          ovr_en  [128];
  logic [7:0]  ovr_val [128];

  sp_cfg_ctrl #(.DEPTH(DEPTH), .AW(AW), .RST_CYCLES(RSTC), .WAKE_CYCLES(WAKEC),
                .GAP_CYCLES(GAPC), .MISO_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .verify_en(verify_en), .n_entries(n_entries),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .ready(ready), .err(err), .err_cnt(err_cnt), .err_idx(err_idx),
    .sp_nrst(sp_nrst), .sp_spi_cs(sp_spi_cs), .sp_spi_mosi(sp_spi_mosi), .sp_spi_miso(sp_spi_miso)
  );

  always #5 clk = ~clk;

  // Cycle counter, steps on every active edge
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural chip: stores written registers, answers reads MISO_LAT late
  logic [15:0] chip_sh = '0;
  int          chip_bits = 0;
  logic        chip_pend = 1'b0;
  logic        chip_rw = 1'b0;
  logic [7:0]  chip_rval = '0;
  logic [7:0]  chip_mem [128];
  always @(negedge clk) begin
    sp_spi_miso = chip_pend;
    chip_pend   = 1'b0;
    if (sp_spi_cs) begin
      chip_bits = 0;
    end else begin
      if (chip_bits == 8) begin
        chip_rw   = chip_sh[7];
        chip_rval = ovr_en[chip_sh[6:0]] ? ovr_val[chip_sh[6:0]] : chip_mem[chip_sh[6:0]];
      end
      if (chip_bits >= 8 && chip_bits <= 15 && !chip_rw) chip_pend = chip_rval[15 - chip_bits];
      chip_sh = {chip_sh[14:0], sp_spi_mosi};
      chip_bits++;
      if (chip_bits == 16 && chip_sh[15]) chip_mem[chip_sh[14:8]] = chip_sh[7:0];
    end
  end

  // Monitor: pops expected frames / end-of-sequence status as the DUT presents them
  logic [15:0] mon_sh = '0;
  int          mon_bits = 0;
  int          mon_rel = 0;
  always @(negedge clk) begin
    frame_t  f;
    status_t st;
    int      rel;
    if (abort) begin
      mon_bits = 0;
    end else if (!sp_spi_cs) begin
      if (mon_bits == 0) mon_rel = cyc - s_start;
      mon_sh = {mon_sh[14:0], sp_spi_mosi};
      mon_bits++;
      if (mon_bits == 16) begin
        mon_bits = 0;
        if (exp_frames.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL frame_extra: got 0x%0h expected no frame", mon_sh);
        end else begin
          f = exp_frames.pop_front();
          check("frame_val", int'(mon_sh), int'(f.val));
          check("frame_start", mon_rel, f.rel);
        end
      end
    end else if (mon_bits != 0) begin
      n_tests++; n_fail++;
      $display("FAIL frame_len: got %0d bits expected 16", mon_bits);
      mon_bits = 0;
    end
    if (done && !abort) begin
      done_count++;
      if (exp_status.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done_extra: got done pulse expected none");
      end else begin
        st = exp_status.pop_front();
        check("done_cycle", cyc - s_start, st.rel);
        check("done_busy", int'(busy), 0);
        check("err", int'(err), st.err);
        check("err_cnt", int'(err_cnt), st.cnt);
        check("err_idx", int'(err_idx), st.idx);
        check("ready", int'(ready), st.rdy);
      end
    end
    if (seq_active) begin
      rel = cyc - s_start;
      if (rel == 1) begin
        check("busy_after_start", int'(busy), 1);
        check("ready_dropped", int'(ready), 0);
        check("err_cleared", int'(err), 0);
        check("err_cnt_cleared", int'(err_cnt), 0);
        check("nrst_low_first", int'(sp_nrst), 0);
      end
      if (rel == RSTC)      check("nrst_low_last", int'(sp_nrst), 0);
      if (rel == RSTC + 1)  check("nrst_released", int'(sp_nrst), 1);
      if (rel == FIRST - 1) check("cs_idle_in_wake", int'(sp_spi_cs), 1);
    end
  end

  // Reference model: derive the frame list and final status from the table
  task automatic build_expect(input int n, input bit ver);
    int      nn, f, cnt, fidx;
    logic [7:0] lw [128];
    logic [6:0] a;
    logic [7:0] got;
    frame_t  fr;
    status_t st;
    nn = (n > DEPTH) ? DEPTH : n;
    f = 0; cnt = 0; fidx = 0;
    for (int i = 0; i < nn; i++) begin
      fr.val = {1'b1, tb_tbl[i]};
      fr.rel = FIRST + SLOT * f;
      f++;
      exp_frames.push_back(fr);
      lw[tb_tbl[i][14:8]] = tb_tbl[i][7:0];
    end
    if (ver) begin
      for (int i = 0; i < nn; i++) begin
        a = tb_tbl[i][14:8];
        fr.val = {1'b0, a, 8'h00};
        fr.rel = FIRST + SLOT * f;
        f++;
        exp_frames.push_back(fr);
        got = ovr_en[a] ? ovr_val[a] : lw[a];
        if (got != tb_tbl[i][7:0]) begin
          if (cnt == 0) fidx = i;
          cnt++;
        end
      end
    end
    st.rel = FIRST + SLOT * f;
    st.err = (cnt != 0) ? 1 : 0;
    st.cnt = (cnt > 31) ? 31 : cnt;
    st.idx = fidx;
    st.rdy = (cnt == 0) ? 1 : 0;
    exp_status.push_back(st);
  endtask

  task automatic write_entry(input int i, input logic [14:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = AW'(i); tbl_data = d;
    tb_tbl[i] = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic start_seq(input int n, input bit ver);
    build_expect(n, ver);
    @(negedge clk);
    dc_before  = done_count;
    s_start    = cyc;
    seq_active = 1'b1;
    verify_en  = ver;
    n_entries  = (AW+1)'(n);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    verify_en  = 1'($urandom);
    n_entries  = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input bit disturb);
    int c;
    c = 0;
    while (done_count == dc_before && c < 3000) begin
      @(negedge clk);
      c++;
      if (disturb) begin
        if (c == 40) start = 1'b1;
        else if (c == 41) start = 1'b0;
        if (c == 50) begin tbl_we = 1'b1; tbl_addr = 4'd1; tbl_data = ~tb_tbl[1]; end
        else if (c == 51) tbl_we = 1'b0;
      end
    end
    check("seq_done_seen", done_count - dc_before, 1);
    check("frames_left", exp_frames.size(), 0);
    check("status_left", exp_status.size(), 0);
    seq_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_seq(input int n, input bit ver, input bit disturb);
    start_seq(n, ver);
    wait_done(disturb);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin ovr_en[a] = 1'b0; ovr_val[a] = 8'h00; end
    repeat (3) @(negedge clk);
    check("rst_nrst", int'(sp_nrst), 0);
    check("rst_cs", int'(sp_spi_cs), 1);
    check("rst_mosi", int'(sp_spi_mosi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_err_idx", int'(err_idx), 0);
    rst = 1'b0;

    write_entry(0, {7'h05, 8'hA3});
    write_entry(1, {7'h7F, 8'h01});
    for (int i = 2; i < DEPTH; i++) write_entry(i, {7'(8'h10 + i), 8'($urandom)});

    run_seq(2, 1'b0, 1'b0);                      // write only
    run_seq(2, 1'b1, 1'b0);                      // verify pass
    ovr_en[7'h7F] = 1'b1; ovr_val[7'h7F] = 8'h00;
    run_seq(2, 1'b1, 1'b0);                      // verify fail on entry 1
    ovr_en[7'h7F] = 1'b0;
    run_seq(0, 1'b1, 1'b0);                      // empty table
    run_seq(31, 1'b0, 1'b0);                     // clamp to DEPTH

    // Reset in the middle of the first frame, then a clean rerun
    start_seq(2, 1'b1);
    repeat (29) @(negedge clk);
    seq_active = 1'b0;
    abort = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_cs", int'(sp_spi_cs), 1);
    check("midrst_nrst", int'(sp_nrst), 0);
    check("midrst_busy", int'(busy), 0);
    exp_frames.delete();
    exp_status.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    run_seq(2, 1'b1, 1'b0);

    run_seq(16, 1'b1, 1'b1);                     // start and tbl_we while busy

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(0, 2) == 0)
          write_entry(i, {7'($urandom_range(0, 11)), 8'($urandom)});
      for (int a = 0; a < 128; a++) ovr_en[a] = 1'b0;
      for (int j = 0; j < 2; j++)
        if ($urandom_range(0, 1) == 1) begin
          ovr_en[$urandom_range(0, 11)] = 1'b1;
          ovr_val[$urandom_range(0, 11)] = 8'($urandom);
        end
      run_seq($urandom_range(0, 31), 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
